// File: rtl/bus_codes_pkg.sv
// Source/destination code points of the shared 32-bit bus and the transfer
// sequencer state encoding.
package bus_codes_pkg;

    localparam int unsigned N_CODES = 24;

    typedef logic [4:0]         code_t;
    typedef logic [N_CODES-1:0] sel_t;

    localparam code_t SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3,
                      SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7,
                      SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11,
                      SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15,
                      SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHI = 5'd18, SRC_ZLO = 5'd19,
                      SRC_PC  = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22, SRC_C = 5'd23;

    localparam code_t DST_R0  = 5'd0,  DST_R1  = 5'd1,  DST_R2  = 5'd2,  DST_R3  = 5'd3,
                      DST_R4  = 5'd4,  DST_R5  = 5'd5,  DST_R6  = 5'd6,  DST_R7  = 5'd7,
                      DST_R8  = 5'd8,  DST_R9  = 5'd9,  DST_R10 = 5'd10, DST_R11 = 5'd11,
                      DST_R12 = 5'd12, DST_R13 = 5'd13, DST_R14 = 5'd14, DST_R15 = 5'd15,
                      DST_HI  = 5'd16, DST_LO  = 5'd17, DST_PC  = 5'd18, DST_MDR = 5'd19,
                      DST_MAR = 5'd20, DST_Y   = 5'd21, DST_IR  = 5'd22, DST_OUTPORT = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LATCH,
        ST_ERR
    } xfer_state_t;

    function automatic logic code_legal(code_t c);
        return c < 5'(N_CODES);
    endfunction

endpackage

// File: rtl/bus_xfer_sequencer_if.sv
// Command handshake and bus strobe bundle between the control unit (master)
// and the transfer sequencer (slave).
interface bus_xfer_sequencer_if;
    import bus_codes_pkg::*;

    logic  cmd_valid;
    code_t cmd_src;
    code_t cmd_dst;
    logic  cmd_ready;
    sel_t  out_sel;
    sel_t  in_en;
    logic  busy;
    logic  done;
    logic  err;

    modport master (
        output cmd_valid, cmd_src, cmd_dst,
        input  cmd_ready, out_sel, in_en, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_src, cmd_dst,
        output cmd_ready, out_sel, in_en, busy, done, err
    );

endinterface

// File: rtl/bus_xfer_fifo.sv
// Synchronous command FIFO with asynchronous clear; pushes while full and pops
// while empty are ignored.
module bus_xfer_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full from empty when the indices coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Bus transfer sequencer: drives the one-hot source strobe, then pulses the one-hot
// destination enable. Define BUS_XFER_FIFO_EN to queue commands in a FIFO_DEPTH FIFO.
module bus_xfer_sequencer
    import bus_codes_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 clear,
    bus_xfer_sequencer_if.slave  bus
);
    if (SETTLE_CYC > 7 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("bus_xfer_sequencer: SETTLE_CYC must be 0..7 and FIFO_DEPTH a power of 2 >= 2");
    end

    localparam logic [2:0] SETTLE_LD = 3'(SETTLE_CYC);

    function automatic sel_t onehot(code_t c);
        sel_t v;
        v = '0;
        if (code_legal(c)) v[c] = 1'b1;
        return v;
    endfunction

    xfer_state_t state_q, state_d, entry_state;
    code_t       src_q, dst_q;
    logic [2:0]  cnt_q;
    logic        alive_q;
    logic        cmd_ready;
    logic        take;
    code_t       take_src, take_dst;
    sel_t        sel_d, en_d;
    logic        done_d, err_d;

`ifdef BUS_XFER_FIFO_EN
    logic       fifo_full, fifo_empty;
    logic [9:0] fifo_head;

    assign cmd_ready              = alive_q & ~fifo_full;
    assign take                   = ~fifo_empty & (state_q == ST_IDLE || state_q == ST_LATCH);
    assign {take_src, take_dst}   = fifo_head;

    bus_xfer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (bus.cmd_valid & cmd_ready),
        .wdata ({bus.cmd_src, bus.cmd_dst}),
        .pop   (take),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
`else
    assign cmd_ready = alive_q & (state_q == ST_IDLE);
    assign take      = bus.cmd_valid & cmd_ready;
    assign take_src  = bus.cmd_src;
    assign take_dst  = bus.cmd_dst;
`endif

    always_comb begin
        if (!(code_legal(take_src) && code_legal(take_dst))) entry_state = ST_ERR;
        else if (SETTLE_CYC == 0)                            entry_state = ST_LATCH;
        else                                                 entry_state = ST_SETTLE;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (take) state_d = entry_state;
            ST_SETTLE: if (cnt_q <= 3'd1) state_d = ST_LATCH;
            ST_LATCH:  state_d = take ? entry_state : ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d  = '0;
        en_d   = '0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            ST_SETTLE: sel_d = onehot(src_q);
            ST_LATCH: begin
                sel_d  = onehot(src_q);
                en_d   = onehot(dst_q);
                done_d = 1'b1;
            end
            ST_ERR:    err_d = 1'b1;
            default: ;
        endcase
    end

    // alive_q holds cmd_ready low until the first edge after clear releases.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            state_q <= state_d;
            if (take) begin
                src_q <= take_src;
                dst_q <= take_dst;
                cnt_q <= SETTLE_LD;
            end else if (state_q == ST_SETTLE) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.out_sel   = sel_d;
    assign bus.in_en     = en_d;
    assign bus.done      = done_d;
    assign bus.err       = err_d;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: directed and random transfers on a SETTLE_CYC=1
// and a SETTLE_CYC=0 instance, each cycle compared with expectations built from the transfer rules.
module tb_bus_xfer_sequencer;

    localparam int unsigned SETTLE [2] = '{1, 0};

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    bus_xfer_sequencer_if bif0 ();
    bus_xfer_sequencer_if bif1 ();

    bus_xfer_sequencer #(.SETTLE_CYC(SETTLE[0]), .FIFO_DEPTH(4)) u_dut0 (
        .clock (clock), .clear (clear), .bus (bif0)
    );
    bus_xfer_sequencer #(.SETTLE_CYC(SETTLE[1]), .FIFO_DEPTH(4)) u_dut1 (
        .clock (clock), .clear (clear), .bus (bif1)
    );

    logic        valid [2];
    logic [4:0]  csrc  [2];
    logic [4:0]  cdst  [2];
    logic        ready [2];
    logic        busy  [2];
    logic        done  [2];
    logic        err   [2];
    logic [23:0] osel  [2];
    logic [23:0] oen   [2];

    assign bif0.cmd_valid = valid[0];
    assign bif0.cmd_src   = csrc[0];
    assign bif0.cmd_dst   = cdst[0];
    assign bif1.cmd_valid = valid[1];
    assign bif1.cmd_src   = csrc[1];
    assign bif1.cmd_dst   = cdst[1];
    assign ready[0] = bif0.cmd_ready;
    assign ready[1] = bif1.cmd_ready;
    assign busy[0]  = bif0.busy;
    assign busy[1]  = bif1.busy;
    assign done[0]  = bif0.done;
    assign done[1]  = bif1.done;
    assign err[0]   = bif0.err;
    assign err[1]   = bif1.err;
    assign osel[0]  = bif0.out_sel;
    assign osel[1]  = bif1.out_sel;
    assign oen[0]   = bif0.in_en;
    assign oen[1]   = bif1.in_en;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input int d, input logic exp_ready);
        chk_b({tag, "_ready"}, ready[d], exp_ready);
        chk_b({tag, "_busy"},  busy[d],  1'b0);
        chk_v({tag, "_sel"},   osel[d],  24'h0);
        chk_v({tag, "_en"},    oen[d],   24'h0);
        chk_b({tag, "_done"},  done[d],  1'b0);
        chk_b({tag, "_err"},   err[d],   1'b0);
    endtask

    // One command through an idle, FIFO-less instance; called at posedge+1.
    task automatic do_xfer(input int d, input logic [4:0] src, input logic [4:0] dst);
        bit          legal;
        logic [23:0] es, ed;
        legal = (src < 5'd24) && (dst < 5'd24);
        es = legal ? (24'd1 << src) : 24'h0;
        ed = legal ? (24'd1 << dst) : 24'h0;
        chk_b("pre_ready", ready[d], 1'b1);
        valid[d] = 1'b1;
        csrc[d]  = src;
        cdst[d]  = dst;
        @(posedge clock); #1;
        valid[d] = 1'b0;
        csrc[d]  = 5'($urandom);
        cdst[d]  = 5'($urandom);
        if (!legal) begin
            chk_b("err_pulse", err[d],  1'b1);
            chk_v("err_sel",   osel[d], 24'h0);
            chk_v("err_en",    oen[d],  24'h0);
            chk_b("err_done",  done[d], 1'b0);
            chk_b("err_busy",  busy[d], 1'b1);
            chk_b("err_ready", ready[d], 1'b0);
        end else begin
            for (int unsigned k = 1; k <= SETTLE[d]; k++) begin
                chk_v("settle_sel",   osel[d],  es);
                chk_v("settle_en",    oen[d],   24'h0);
                chk_b("settle_done",  done[d],  1'b0);
                chk_b("settle_busy",  busy[d],  1'b1);
                chk_b("settle_ready", ready[d], 1'b0);
                @(posedge clock); #1;
            end
            chk_v("latch_sel",   osel[d],  es);
            chk_v("latch_en",    oen[d],   ed);
            chk_b("latch_done",  done[d],  1'b1);
            chk_b("latch_err",   err[d],   1'b0);
            chk_b("latch_ready", ready[d], 1'b0);
        end
        @(posedge clock); #1;
        chk_quiet("after", d, 1'b1);
    endtask

    task automatic reset_mid();
        bit found;
        found = 1'b0;
        valid[0] = 1'b1;
        csrc[0]  = 5'd2;
        cdst[0]  = 5'd20;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clock); #1;
            if (busy[0] && osel[0] != 24'h0 && !done[0]) found = 1'b1;
        end
        valid[0] = 1'b0;
        chk_b("mid_reached_settle", found, 1'b1);
        chk_v("mid_settle_sel", osel[0], 24'd1 << 2);
        #2 clear = 1'b1;
        #1;
        chk_quiet("mid_clear", 0, 1'b0);
        @(posedge clock);
        #3 clear = 1'b0;
        #1;
        chk_quiet("mid_release", 0, 1'b0);
        @(posedge clock); #1;
        chk_quiet("mid_first_edge", 0, 1'b1);
    endtask

    task automatic hold_test();
        int first, second, low;
        bit acc;
        first  = -1;
        second = -1;
        low    = 0;
        valid[0] = 1'b1;
        csrc[0]  = 5'd7;
        cdst[0]  = 5'd21;
        for (int c = 0; c < 20 && second < 0; c++) begin
            acc = ready[0];
            @(posedge clock); #1;
            if (acc) begin
                if (first < 0) first = c;
                else           second = c;
            end else if (first >= 0) begin
                low++;
            end
        end
        valid[0] = 1'b0;
        chk_i("hold_period", second - first, int'(SETTLE[0]) + 2);
        chk_i("hold_ready_low", low, int'(SETTLE[0]) + 1);
        for (int c = 0; c < 10 && busy[0]; c++) begin
            @(posedge clock); #1;
        end
        chk_b("hold_drained", busy[0], 1'b0);
    endtask

    task automatic fifo_burst();
        logic [4:0] qs [5];
        logic [4:0] qd [5];
        int got, last;
        qs = '{5'd1, 5'd5, 5'd9, 5'd14, 5'd21};
        qd = '{5'd20, 5'd2, 5'd23, 5'd0, 5'd22};
        got  = 0;
        last = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    valid[0] = 1'b1;
                    csrc[0]  = qs[i];
                    cdst[0]  = qd[i];
                    for (int w = 0; w < 50 && !ready[0]; w++) begin
                        @(posedge clock); #1;
                    end
                    @(posedge clock); #1;
                end
                valid[0] = 1'b0;
            end
            begin
                for (int t = 0; t < 60 && got < 5; t++) begin
                    @(posedge clock); #1;
                    if (done[0]) begin
                        chk_v("fifo_order_sel", osel[0], 24'd1 << qs[got]);
                        chk_v("fifo_order_en",  oen[0],  24'd1 << qd[got]);
                        if (got > 0) chk_i("fifo_spacing", t - last, int'(SETTLE[0]) + 1);
                        last = t;
                        got++;
                    end
                end
            end
        join
        chk_i("fifo_done_count", got, 5);
        for (int c = 0; c < 10 && busy[0]; c++) begin
            @(posedge clock); #1;
        end
        chk_b("fifo_drained", busy[0], 1'b0);
    endtask

    initial begin
        int          d, n;
        logic [4:0]  s, t;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0;
            csrc[i]  = '0;
            cdst[i]  = '0;
        end
        #1;
        chk_quiet("rst0", 0, 1'b0);
        chk_quiet("rst1", 1, 1'b0);
        repeat (2) @(posedge clock);
        #3 clear = 1'b0;
        #1;
        chk_b("rel_ready_pre0", ready[0], 1'b0);
        chk_b("rel_ready_pre1", ready[1], 1'b0);
        @(posedge clock); #1;
        chk_b("rel_ready0", ready[0], 1'b1);
        chk_b("rel_ready1", ready[1], 1'b1);

        reset_mid();
`ifdef BUS_XFER_FIFO_EN
        fifo_burst();
`else
        do_xfer(0, 5'd21, 5'd22);
        do_xfer(1, 5'd3,  5'd3);
        do_xfer(0, 5'd25, 5'd4);
        do_xfer(1, 5'd4,  5'd24);
        do_xfer(0, 5'd3,  5'd3);
        do_xfer(1, 5'd23, 5'd0);
        do_xfer(0, 5'd0,  5'd23);
        hold_test();
        for (int r = 0; r < 40; r++) begin
            d = int'($urandom_range(1, 0));
            s = 5'($urandom_range(27, 0));
            t = 5'($urandom_range(27, 0));
            do_xfer(d, s, t);
            n = int'($urandom_range(2, 0));
            for (int k = 0; k < n; k++) begin
                @(posedge clock); #1;
            end
        end
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
